// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file geometry constants
package rf_pkg;
  localparam int WIDTH    = 32;
  localparam int AW       = 4;
  localparam int NREGS    = 16;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/reg_file32_sb_if.sv
// rtl/reg_file32_sb_if.sv - decode/write-back bus into the register file
interface reg_file32_sb_if;
  import rf_pkg::*;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             rd_valid;
  logic             issue_en;
  logic [AW-1:0]    issue_addr;
  logic             busy_a;
  logic             busy_b;
  logic             stall;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b, issue_en, issue_addr,
    input  rd_data_a, rd_data_b, rd_valid, busy_a, busy_b, stall
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b, issue_en, issue_addr,
    output rd_data_a, rd_data_b, rd_valid, busy_a, busy_b, stall
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-write busy bits with same-cycle write-back forwarding
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_en,
  input  logic [AW-1:0] issue_addr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic          busy_a,
  output logic          busy_b
);
  logic [NREGS-1:0] busy;

  // Issue beats write-back on the same register: the new producer is still outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy[ZERO_REG] <= 1'b0;
      for (int i = 1; i < NREGS; i++) begin
        if (issue_en && issue_addr == AW'(i))
          busy[i] <= 1'b1;
        else if (wr_en && wr_addr == AW'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  assign busy_a = busy[rd_addr_a] & ~(wr_en && wr_addr == rd_addr_a);
  assign busy_b = busy[rd_addr_b] & ~(wr_en && wr_addr == rd_addr_b);
endmodule

// File: rtl/reg_file32_sb.sv
// rtl/reg_file32_sb.sv - 16x32 register file, registered read ports with bypass, R0 hardwired
module reg_file32_sb
  import rf_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  reg_file32_sb_if.slave  bus
);
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;
  logic             rd_fire;

  rf_scoreboard u_sb (
    .clk        (clk),
    .reset      (reset),
    .issue_en   (bus.issue_en),
    .issue_addr (bus.issue_addr),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .rd_addr_a  (bus.rd_addr_a),
    .rd_addr_b  (bus.rd_addr_b),
    .busy_a     (bus.busy_a),
    .busy_b     (bus.busy_b)
  );

  assign bus.stall = bus.rd_en & (bus.busy_a | bus.busy_b);
  assign rd_fire   = bus.rd_en & ~bus.stall;

  always_comb begin
    next_a = regs[bus.rd_addr_a];
    if (bus.rd_addr_a == AW'(ZERO_REG))
      next_a = '0;
    else if (bus.wr_en && bus.wr_addr == bus.rd_addr_a)
      next_a = bus.wr_data;
  end

  always_comb begin
    next_b = regs[bus.rd_addr_b];
    if (bus.rd_addr_b == AW'(ZERO_REG))
      next_b = '0;
    else if (bus.wr_en && bus.wr_addr == bus.rd_addr_b)
      next_b = bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (bus.wr_en && bus.wr_addr != AW'(ZERO_REG)) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Operands hold across a stall so execute keeps seeing the last issued pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rd_data_a <= '0;
      bus.rd_data_b <= '0;
      bus.rd_valid  <= 1'b0;
    end else begin
      bus.rd_valid <= rd_fire;
      if (rd_fire) begin
        bus.rd_data_a <= next_a;
        bus.rd_data_b <= next_b;
      end
    end
  end
endmodule

// File: tb/tb_reg_file32_sb.sv
// tb/tb_reg_file32_sb.sv - directed self-checking bench for reg_file32_sb
module tb_reg_file32_sb;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  reg_file32_sb_if bus ();

  reg_file32_sb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    bus.issue_en = 1'b0; bus.issue_addr = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    // 1: reset wins over a concurrent write, read and issue
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 32'hDEADBEEF;
    bus.rd_en = 1'b1; bus.rd_addr_a = 4'd3;
    bus.issue_en = 1'b1; bus.issue_addr = 4'd3;
    tick();
    check("rst_valid_c1", {31'b0, bus.rd_valid}, 32'd0);
    check("rst_busy_c1", {31'b0, bus.busy_a}, 32'd0);
    tick();
    check("rst_valid_c2", {31'b0, bus.rd_valid}, 32'd0);
    check("rst_rd_a", bus.rd_data_a, 32'd0);
    check("rst_stall", {31'b0, bus.stall}, 32'd0);
    reset = 1'b0;
    idle();
    bus.rd_en = 1'b1; bus.rd_addr_a = 4'd3;
    tick();
    check("r3_after_rst", bus.rd_data_a, 32'd0);
    check("r3_valid", {31'b0, bus.rd_valid}, 32'd1);

    // 2: plain write then read
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 32'h0088140A;
    tick();
    idle();
    bus.rd_en = 1'b1; bus.rd_addr_a = 4'd5; bus.rd_addr_b = 4'd0;
    tick();
    check("r5_a", bus.rd_data_a, 32'h0088140A);
    check("r0_b", bus.rd_data_b, 32'd0);
    check("r5_valid", {31'b0, bus.rd_valid}, 32'd1);

    // 3: same-cycle bypass on port A, port B from array
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 32'h2288140A;
    bus.rd_en = 1'b1; bus.rd_addr_a = 4'd7; bus.rd_addr_b = 4'd5;
    tick();
    check("bypass_a", bus.rd_data_a, 32'h2288140A);
    check("bypass_b", bus.rd_data_b, 32'h0088140A);
    idle();
    tick();
    check("idle_valid", {31'b0, bus.rd_valid}, 32'd0);
    check("idle_hold_a", bus.rd_data_a, 32'h2288140A);

    // 4: R0 ignores writes and issues
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 32'hAAAAAA88;
    tick();
    idle();
    bus.rd_en = 1'b1; bus.rd_addr_a = 4'd0; bus.rd_addr_b = 4'd7;
    tick();
    check("r0_read", bus.rd_data_a, 32'd0);
    check("r7_read", bus.rd_data_b, 32'h2288140A);
    idle();
    bus.issue_en = 1'b1; bus.issue_addr = 4'd0;
    tick();
    idle();
    #1;
    check("r0_busy", {31'b0, bus.busy_a}, 32'd0);

    // 5: issue R9, stalled read, write-back clears the hazard
    bus.issue_en = 1'b1; bus.issue_addr = 4'd9;
    tick();
    idle();
    bus.rd_en = 1'b1; bus.rd_addr_a = 4'd9; bus.rd_addr_b = 4'd5;
    #1;
    check("r9_stall", {31'b0, bus.stall}, 32'd1);
    check("r9_busy_a", {31'b0, bus.busy_a}, 32'd1);
    check("r5_busy_b", {31'b0, bus.busy_b}, 32'd0);
    tick();
    check("stall_valid", {31'b0, bus.rd_valid}, 32'd0);
    check("stall_hold_a", bus.rd_data_a, 32'd0);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 32'hC0C0C0C0;
    #1;
    check("wb_stall", {31'b0, bus.stall}, 32'd0);
    tick();
    check("wb_a", bus.rd_data_a, 32'hC0C0C0C0);
    check("wb_valid", {31'b0, bus.rd_valid}, 32'd1);
    idle();
    bus.rd_addr_a = 4'd9;
    #1;
    check("r9_cleared", {31'b0, bus.busy_a}, 32'd0);

    // double issue then one write clears; same register on both sources
    bus.issue_en = 1'b1; bus.issue_addr = 4'd6;
    tick();
    tick();
    idle();
    bus.rd_addr_a = 4'd6; bus.rd_addr_b = 4'd6;
    #1;
    check("r6_busy_a", {31'b0, bus.busy_a}, 32'd1);
    check("r6_busy_b", {31'b0, bus.busy_b}, 32'd1);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd6; bus.wr_data = 32'h00000066;
    tick();
    bus.wr_en = 1'b0;
    #1;
    check("r6_clear", {31'b0, bus.busy_a}, 32'd0);

    // 6: issue and write-back on R4 together, then reset mid-hazard
    idle();
    bus.issue_en = 1'b1; bus.issue_addr = 4'd4;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd4; bus.wr_data = 32'h12345678;
    tick();
    idle();
    bus.rd_addr_a = 4'd4;
    #1;
    check("r4_busy", {31'b0, bus.busy_a}, 32'd1);
    check("r4_data", dut.regs[4], 32'h12345678);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("r4_busy_rst", {31'b0, bus.busy_a}, 32'd0);
    check("r4_data_rst", dut.regs[4], 32'd0);
    check("rd_a_rst", bus.rd_data_a, 32'd0);
    bus.rd_en = 1'b1;
    tick();
    check("r4_read_rst", bus.rd_data_a, 32'd0);
    check("r4_read_valid", {31'b0, bus.rd_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
